// File: rtl/subleq_pkg.sv
// Shared types and constants for the ABC instruction-group fetch unit.
package subleq_pkg;

   // Default operand and address widths.
   localparam int DATA_W_DEF = 64;
   localparam int ADDR_W_DEF = 64;

   // Fetch controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Slot index: which of the five words is being fetched.
   typedef logic [2:0] slot_t;

   localparam slot_t SLOT_A  = 3'd0;  // word at pc
   localparam slot_t SLOT_B  = 3'd1;  // word at pc+1
   localparam slot_t SLOT_C  = 3'd2;  // word at pc+2
   localparam slot_t SLOT_MA = 3'd3;  // word at address A
   localparam slot_t SLOT_MB = 3'd4;  // word at address B

endpackage

// File: rtl/abc_fetch_unit.sv
// Fetches one ABC instruction group: the three words at pc, pc+1, pc+2
// (A, B, C) followed by the two words those first two point at (mem[A],
// mem[B]). One read is outstanding at a time; done pulses once all five
// operand registers hold the new group.
module abc_fetch_unit
   import subleq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [DATA_W-1:0] c_out,
   output logic [DATA_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_b,
   output logic              done
);

   state_e            r_state;
   state_e            w_next_state;
   slot_t             r_idx;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_c;
   logic [DATA_W-1:0] r_ma;
   logic [DATA_W-1:0] r_mb;
   logic [ADDR_W-1:0] w_slot_addr;
   logic              w_accept;
   logic              w_capture;

   // State register; reset wins over any start in the same cycle.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode plus the accept/capture strobes and request valid.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      w_next_state  = r_state;
      w_accept      = 1'b0;
      w_capture     = 1'b0;
      mem_req_valid = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               w_next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Responses are only meaningful here; elsewhere they are dropped.
            if (mem_rsp_valid) begin
               w_capture    = 1'b1;
               w_next_state = (r_idx == SLOT_MB) ? ST_DONE : ST_REQ;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Address for the current slot; pc offsets wrap modulo 2^ADDR_W.
   always_comb begin
      w_slot_addr = '0;
      case (r_idx)
         SLOT_A:  w_slot_addr = r_pc;
         SLOT_B:  w_slot_addr = r_pc + ADDR_W'(1);
         SLOT_C:  w_slot_addr = r_pc + ADDR_W'(2);
         SLOT_MA: w_slot_addr = ADDR_W'(r_a);
         SLOT_MB: w_slot_addr = ADDR_W'(r_b);
         default: w_slot_addr = '0;
      endcase
   end

   // Datapath: latch pc on accept, route each response into its slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: operand registers are reset because they drive outputs directly.
         r_pc  <= '0;
         r_idx <= SLOT_A;
         r_a   <= '0;
         r_b   <= '0;
         r_c   <= '0;
         r_ma  <= '0;
         r_mb  <= '0;
      end else if (w_accept) begin
         r_pc  <= pc;
         r_idx <= SLOT_A;
      end else if (w_capture) begin
         case (r_idx)
            SLOT_A:  r_a  <= mem_rsp_data;
            SLOT_B:  r_b  <= mem_rsp_data;
            SLOT_C:  r_c  <= mem_rsp_data;
            SLOT_MA: r_ma <= mem_rsp_data;
            SLOT_MB: r_mb <= mem_rsp_data;
            default: ;
         endcase
         if (r_idx != SLOT_MB) begin
            r_idx <= r_idx + 3'd1;
         end
      end
   end

   // Address is held stable through REQ (r_idx, r_pc, r_a, r_b do not move
   // there) and forced to zero whenever no request is being presented.
   assign mem_req_addr = mem_req_valid ? w_slot_addr : '0;
   assign busy         = (r_state != ST_IDLE);
   assign done         = (r_state == ST_DONE);
   assign a_out        = r_a;
   assign b_out        = r_b;
   assign c_out        = r_c;
   assign mem_a        = r_ma;
   assign mem_b        = r_mb;

endmodule

// File: tb/tb_abc_fetch_unit.sv
// Self-checking bench for abc_fetch_unit: a memory responder with random
// stalls, delays and stray responses, a progress-count reference model, a
// per-cycle compare process, and directed scenarios with literal results.
module tb_abc_fetch_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] pc;
   logic        busy;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;
   logic [63:0] a_out;
   logic [63:0] b_out;
   logic [63:0] c_out;
   logic [63:0] mem_a;
   logic [63:0] mem_b;
   logic        done;

   abc_fetch_unit #(.DATA_W(64), .ADDR_W(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .pc            (pc),
      .busy          (busy),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .a_out         (a_out),
      .b_out         (b_out),
      .c_out         (c_out),
      .mem_a         (mem_a),
      .mem_b         (mem_b),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- memory contents ----------------
   logic [63:0] mem_tbl [logic [63:0]];

   function automatic logic [63:0] mem_read(input logic [63:0] a);
      if (mem_tbl.exists(a)) return mem_tbl[a];
      return {a[31:0] ^ 32'h5a5a_1234, a[63:32] + 32'h0000_9e37};
   endfunction

   // ---------------- stimulus knobs / responder state ----------------
   bit          k_rst = 1'b1;
   bit          k_start = 1'b0;
   bit          k_force_rsp = 1'b0;
   logic [63:0] k_pc = '0;
   int          ready_pct = 100;
   int          stray_pct = 0;
   int          dly_max = 0;
   int          stall_slot = -1;
   int          stall_left = 0;
   bit          pend = 1'b0;
   logic [63:0] pend_addr = '0;
   int          pend_dly = 0;
   logic [63:0] hs_addrs [$];
   int          hs_count = 0;
   int          done_seen = 0;
   int          done_cyc = 0;

   // One clock cycle: drive inputs just after the edge, observe at negedge.
   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      rst   = k_rst;
      start = k_start;
      pc    = k_pc;
      if (stall_left > 0 && mem_req_valid === 1'b1 && hs_count == stall_slot) begin
         mem_req_ready = 1'b0;
         stall_left--;
      end else begin
         mem_req_ready = ($urandom_range(99) < ready_pct);
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom};
      if (k_rst) pend = 1'b0;
      if (k_force_rsp) begin
         mem_rsp_valid = 1'b1;
      end else if (pend) begin
         if (pend_dly == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_read(pend_addr);
            pend          = 1'b0;
         end else begin
            pend_dly--;
         end
      end else if ($urandom_range(99) < stray_pct) begin
         mem_rsp_valid = 1'b1;
      end
      @(negedge clk);
      if (mem_req_valid === 1'b1 && mem_req_ready) begin
         hs_addrs.push_back(mem_req_addr);
         hs_count++;
         pend      = 1'b1;
         pend_addr = mem_req_addr;
         pend_dly  = $urandom_range(dly_max, 0);
      end
      if (done === 1'b1) begin
         done_seen++;
         done_cyc = cyc;
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks a fetch as "how many words received, is one outstanding".
   bit          m_valid = 1'b0;
   bit          m_active = 1'b0;
   bit          m_out = 1'b0;
   bit          m_done = 1'b0;
   int          m_slot = 0;
   logic [63:0] m_pc = '0;
   logic [63:0] m_word [5];

   task automatic model_step();
      if (rst) begin
         m_valid  = 1'b1;
         m_active = 1'b0;
         m_out    = 1'b0;
         m_done   = 1'b0;
         m_slot   = 0;
         for (int i = 0; i < 5; i++) m_word[i] = '0;
      end else if (m_valid) begin
         if (m_done) begin
            m_done = 1'b0;
         end else if (!m_active) begin
            if (start) begin
               m_active = 1'b1;
               m_pc     = pc;
               m_slot   = 0;
               m_out    = 1'b0;
            end
         end else if (!m_out) begin
            if (mem_req_ready) m_out = 1'b1;
         end else if (mem_rsp_valid) begin
            m_word[m_slot] = mem_rsp_data;
            m_slot++;
            m_out = 1'b0;
            if (m_slot == 5) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   function automatic logic m_req();
      return m_active && !m_out;
   endfunction

   function automatic logic [63:0] m_addr();
      if (!m_req()) return '0;
      if (m_slot < 3) return m_pc + 64'(m_slot);
      return m_word[m_slot - 3];
   endfunction

   // Compare every cycle once the model has seen a reset.
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("cmp_busy",      busy,          m_active || m_done);
         check("cmp_done",      done,          m_done);
         check("cmp_req_valid", mem_req_valid, m_req());
         check("cmp_req_addr",  mem_req_addr,  m_addr());
         check("cmp_a_out",     a_out,         m_word[0]);
         check("cmp_b_out",     b_out,         m_word[1]);
         check("cmp_c_out",     c_out,         m_word[2]);
         check("cmp_mem_a",     mem_a,         m_word[3]);
         check("cmp_mem_b",     mem_b,         m_word[4]);
      end
   end

   // Issue start at pc, optionally keep start high with random pc while
   // busy, and wait (bounded) for done. Returns start-to-done latency.
   task automatic run_fetch(input logic [63:0] p, input bit hold_start, output int lat);
      int d0;
      int sc;
      hs_addrs.delete();
      hs_count = 0;
      d0       = done_seen;
      k_start  = 1'b1;
      k_pc     = p;
      step();
      sc      = cyc;
      k_start = hold_start;
      for (int i = 0; i < 200 && done_seen == d0; i++) begin
         if (hold_start) k_pc = {$urandom, $urandom};
         step();
      end
      k_start = 1'b0;
      check("fetch_completes", 64'(done_seen - d0), 64'd1);
      lat = done_cyc - sc;
   endtask

   task automatic check_group(input string tag);
      check({tag, "_a"},     a_out, 64'd20);
      check({tag, "_b"},     b_out, 64'd21);
      check({tag, "_c"},     c_out, 64'd30);
      check({tag, "_mem_a"}, mem_a, 64'd5);
      check({tag, "_mem_b"}, mem_b, 64'd7);
   endtask

   initial begin
      int lat;
      int d0;
      rst           = 1'b1;
      start         = 1'b0;
      pc            = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;

      // Reset state.
      k_rst = 1'b1;
      repeat (3) step();
      k_rst = 1'b0;
      step();
      check("rst_busy",      busy,          1'b0);
      check("rst_done",      done,          1'b0);
      check("rst_req_valid", mem_req_valid, 1'b0);
      check("rst_req_addr",  mem_req_addr,  64'd0);
      check("rst_a_out",     a_out,         64'd0);
      check("rst_mem_b",     mem_b,         64'd0);

      // Zero-wait fetch of the reference group.
      mem_tbl[64'd10] = 64'd20;
      mem_tbl[64'd11] = 64'd21;
      mem_tbl[64'd12] = 64'd30;
      mem_tbl[64'd20] = 64'd5;
      mem_tbl[64'd21] = 64'd7;
      run_fetch(64'd10, 1'b0, lat);
      check("basic_latency", 64'(lat), 64'd11);
      check("basic_n_req", 64'(hs_addrs.size()), 64'd5);
      check("basic_addr0", hs_addrs[0], 64'd10);
      check("basic_addr1", hs_addrs[1], 64'd11);
      check("basic_addr2", hs_addrs[2], 64'd12);
      check("basic_addr3", hs_addrs[3], 64'd20);
      check("basic_addr4", hs_addrs[4], 64'd21);
      check_group("basic");
      repeat (2) step();

      // Three-cycle ready stall on slot 1.
      stall_slot = 1;
      stall_left = 3;
      run_fetch(64'd10, 1'b0, lat);
      check("stall_latency", 64'(lat), 64'd14);
      check("stall_addr1", hs_addrs[1], 64'd11);
      check_group("stall");
      stall_slot = -1;
      repeat (2) step();

      // Address wrap at the top of the address space.
      run_fetch(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, lat);
      check("wrap_latency", 64'(lat), 64'd11);
      check("wrap_addr0", hs_addrs[0], 64'hFFFF_FFFF_FFFF_FFFE);
      check("wrap_addr1", hs_addrs[1], 64'hFFFF_FFFF_FFFF_FFFF);
      check("wrap_addr2", hs_addrs[2], 64'd0);
      repeat (2) step();

      // start held high with changing pc while busy.
      d0 = done_seen;
      run_fetch(64'd10, 1'b1, lat);
      repeat (15) step();
      check("busy_start_one_done", 64'(done_seen - d0), 64'd1);
      check("busy_start_latency", 64'(lat), 64'd11);
      check("busy_start_addr0", hs_addrs[0], 64'd10);
      check_group("busy_start");

      // Reset in the WAIT of slot 3, stray response the following cycle.
      hs_addrs.delete();
      hs_count = 0;
      k_start  = 1'b1;
      k_pc     = 64'd10;
      step();
      k_start = 1'b0;
      for (int i = 0; i < 100 && hs_count < 4; i++) step();
      check("abort_reached_slot3", 64'(hs_count), 64'd4);
      d0    = done_seen;
      k_rst = 1'b1;
      step();
      k_rst       = 1'b0;
      k_force_rsp = 1'b1;
      step();
      k_force_rsp = 1'b0;
      repeat (12) step();
      check("abort_no_done", 64'(done_seen - d0), 64'd0);
      check("abort_busy",    busy,  1'b0);
      check("abort_a_out",   a_out, 64'd0);
      check("abort_c_out",   c_out, 64'd0);
      check("abort_mem_a",   mem_a, 64'd0);

      // Stray responses while slot 0 request is stalled.
      stall_slot = 0;
      stall_left = 3;
      stray_pct  = 100;
      run_fetch(64'd10, 1'b0, lat);
      check("stray_latency", 64'(lat), 64'd14);
      check_group("stray");
      stray_pct  = 0;
      stall_slot = -1;
      repeat (2) step();

      // Randomized traffic: stalls, response delay, strays, resets, starts.
      mem_tbl.delete();
      ready_pct = 60;
      stray_pct = 25;
      dly_max   = 2;
      d0        = done_seen;
      for (int i = 0; i < 2500; i++) begin
         k_rst   = ($urandom_range(99) < 2);
         k_start = ($urandom_range(3) == 0);
         case ($urandom_range(2))
            0:       k_pc = {$urandom, $urandom};
            1:       k_pc = 64'hFFFF_FFFF_FFFF_FFFD + 64'($urandom_range(2));
            default: k_pc = 64'($urandom_range(50));
         endcase
         step();
      end
      k_rst   = 1'b0;
      k_start = 1'b0;
      repeat (20) step();
      check("random_saw_dones", 64'(done_seen > d0), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
